// File: rtl/wordlist_pkg.sv
// Shared definitions for the wordlist indexer: delimiter constants, scan states
// and the {start, len} layout of one index-table entry.
package wordlist_pkg;

    localparam logic [7:0] EOL = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest supported entry; the table stores the low ADDR_W / LEN_W bits.
    typedef struct packed {
        logic [31:0] start;
        logic [7:0]  len;
    } entry_t;

endpackage

// File: rtl/wordlist_idx_ram.sv
// Index table: one write port, one registered read port; a same-address
// write and read in one cycle return the previous contents.
module wordlist_idx_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;

    always_comb rdata_d = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/wordlist_indexer.sv
// Scans an EOL-separated byte stream and records {offset, length} of every word.
// Optional CRLF_STRIP_EN: a CR right before the terminating EOL is not counted.
module wordlist_indexer
    import wordlist_pkg::*;
#(
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 1024,
    parameter int LEN_W   = 6,
    parameter int MAX_LEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ADDR_W-1:0]        rd_start,
    output logic [LEN_W-1:0]         rd_len,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic [15:0]              drop_count,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Length counter saturates at MAX_LEN+2 so a stripped CR still leaves
    // an over-long word recognisably over-long.
    localparam int NW = $clog2(MAX_LEN + 3);
    localparam int EW = ADDR_W + LEN_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d, wstart_q, wstart_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic              cr_q, cr_d;
    logic [CW-1:0]     wc_q, wc_d;
    logic [15:0]       drop_q, drop_d;
    logic              ovf_q, ovf_d, done_q, done_d, rd_vld_q, rd_vld_d;
    logic              acc, is_eol, term, we;
    logic [NW:0]       eff;
    logic [EW-1:0]     rdata;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) state_d = SCAN;
        else if (state_q == SCAN && acc && in_last) state_d = DONE;
    end

    always_comb in_ready = (state_q == SCAN);

    // A byte presented alongside start belongs to the abandoned scan.
    assign acc    = in_valid && in_ready && !start;
    assign is_eol = (in_data == EOL);
    assign term   = acc && (is_eol || in_last);

    always_comb begin
        offset_d = offset_q;
        wstart_d = wstart_q;
        cnt_d    = cnt_q;
        cr_d     = cr_q;
        wc_d     = wc_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        done_d   = done_q;
        we       = 1'b0;
        rd_vld_d = ({1'b0, rd_addr} < wc_q);
        if (is_eol) eff = {1'b0, cnt_q} - {{NW{1'b0}}, cr_q};
        else        eff = {1'b0, cnt_q} + (NW+1)'(1);

        if (start) begin
            offset_d = '0;
            wstart_d = '0;
            cnt_d    = '0;
            cr_d     = 1'b0;
            wc_d     = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
            done_d   = 1'b0;
            rd_vld_d = 1'b0;
        end else if (acc) begin
            offset_d = offset_q + 1'b1;
            if (term) begin
                wstart_d = offset_q + 1'b1;
                cnt_d    = '0;
                cr_d     = 1'b0;
                if (eff != '0) begin
                    if (eff > (NW+1)'(MAX_LEN)) begin
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end else if (wc_q == CW'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        we   = 1'b1;
                        wc_d = wc_q + 1'b1;
                    end
                end
                if (in_last) done_d = 1'b1;
            end else begin
                if (cnt_q != NW'(MAX_LEN + 2)) cnt_d = cnt_q + 1'b1;
`ifdef CRLF_STRIP_EN
                cr_d = (in_data == CR);
`else
                cr_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
            wstart_q <= '0;
            cnt_q    <= '0;
            cr_q     <= 1'b0;
            wc_q     <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            offset_q <= offset_d;
            wstart_q <= wstart_d;
            cnt_q    <= cnt_d;
            cr_q     <= cr_d;
            wc_q     <= wc_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    wordlist_idx_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wc_q[AW-1:0]),
        .wdata ({wstart_q, LEN_W'(eff)}),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    assign rd_start   = rd_vld_q ? rdata[EW-1:LEN_W] : '0;
    assign rd_len     = rd_vld_q ? rdata[LEN_W-1:0]  : '0;
    assign word_count = wc_q;
    assign drop_count = drop_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
endmodule
